// File: rtl/hamming74_pkg.sv
// Shared types and constants for the Hamming(7,4) receive path.
package hamming74_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam int unsigned CW_W      = 7;
   localparam int unsigned NIB_W     = 4;
   localparam int unsigned SYN_W     = 3;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_IDX_W = 3;

   // Codeword bit index of Hamming position pN is N-1
   localparam int unsigned P1 = 0;
   localparam int unsigned P2 = 1;
   localparam int unsigned P3 = 2;
   localparam int unsigned P4 = 3;
   localparam int unsigned P5 = 4;
   localparam int unsigned P6 = 5;
   localparam int unsigned P7 = 6;

endpackage

// File: rtl/hamming74_rx_ctrl_if.sv
// Line-side inputs and byte-side handshake/status of the Hamming(7,4) receiver.
interface hamming74_rx_ctrl_if
   import hamming74_pkg::*;
#(
   parameter int unsigned CNT_W = 8
);
   logic              ena;
   logic              baud_tick;
   logic              rx_in;
   logic [BYTE_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              corr_pulse;
   logic              frame_err;
   logic              overrun;
   logic [CNT_W-1:0]  corr_cnt;
   logic              busy;

   modport master (
      output ena, baud_tick, rx_in, out_ready,
      input  out_data, out_valid, corr_pulse, frame_err, overrun, corr_cnt, busy
   );

   modport slave (
      input  ena, baud_tick, rx_in, out_ready,
      output out_data, out_valid, corr_pulse, frame_err, overrun, corr_cnt, busy
   );
endinterface

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-bit corrector: codeword -> syndrome and data nibble.
module hamming74_correct
   import hamming74_pkg::*;
(
   input  logic [CW_W-1:0]  i_cw,
   output logic [NIB_W-1:0] o_nibble_c,
   output logic [SYN_W-1:0] o_syndrome_c
);

   logic [SYN_W-1:0] w_syn;
   logic [CW_W-1:0]  w_fixed;

   assign w_syn = {i_cw[P4] ^ i_cw[P5] ^ i_cw[P6] ^ i_cw[P7],
                   i_cw[P2] ^ i_cw[P3] ^ i_cw[P6] ^ i_cw[P7],
                   i_cw[P1] ^ i_cw[P3] ^ i_cw[P5] ^ i_cw[P7]};

   // Nonzero syndrome names the 1-based position of the flipped bit
   always_comb begin
      w_fixed = i_cw;
      if (w_syn != '0) begin
         w_fixed[w_syn - SYN_W'(1)] = ~i_cw[w_syn - SYN_W'(1)];
      end
   end

   assign o_nibble_c   = {w_fixed[P7], w_fixed[P6], w_fixed[P5], w_fixed[P3]};
   assign o_syndrome_c = w_syn;

endmodule

// File: rtl/hamming74_rx_ctrl.sv
// Frames serial Hamming(7,4) codewords, corrects them, pairs nibbles into bytes
// and presents them through a one-entry valid/ready holding register.
module hamming74_rx_ctrl
   import hamming74_pkg::*;
#(
   parameter bit          LSB_NIBBLE_FIRST = 1'b1,
   parameter int unsigned CNT_W            = 8
) (
   input  logic               clk,
   input  logic               rst,
   hamming74_rx_ctrl_if.slave bus
);

   state_t                r_state,      w_state_nxt;
   logic [BIT_IDX_W-1:0]  r_bit_idx,    w_bit_idx_nxt;
   logic [CW_W-1:0]       r_cw,         w_cw_nxt;
   logic                  r_nib_sel,    w_nib_sel_nxt;
   logic [NIB_W-1:0]      r_nib_hold,   w_nib_hold_nxt;
   logic [BYTE_W-1:0]     r_out_data,   w_out_data_nxt;
   logic                  r_out_valid,  w_out_valid_nxt;
   logic                  r_corr_pulse, w_corr_pulse_nxt;
   logic                  r_frame_err,  w_frame_err_nxt;
   logic                  r_overrun,    w_overrun_nxt;
   logic [CNT_W-1:0]      r_corr_cnt,   w_corr_cnt_nxt;
   logic                  r_busy,       w_busy_nxt;

   logic [NIB_W-1:0]      w_nib;
   logic [SYN_W-1:0]      w_syn;
   logic [BYTE_W-1:0]     w_byte;

   hamming74_correct u_correct (
      .i_cw         (r_cw),
      .o_nibble_c   (w_nib),
      .o_syndrome_c (w_syn)
   );

   assign w_byte = LSB_NIBBLE_FIRST ? {w_nib, r_nib_hold} : {r_nib_hold, w_nib};

   // Next-state, nibble pairing and output-register update
   always_comb begin
      w_state_nxt      = r_state;
      w_bit_idx_nxt    = r_bit_idx;
      w_cw_nxt         = r_cw;
      w_nib_sel_nxt    = r_nib_sel;
      w_nib_hold_nxt   = r_nib_hold;
      w_out_data_nxt   = r_out_data;
      w_out_valid_nxt  = r_out_valid && !bus.out_ready;
      w_corr_pulse_nxt = 1'b0;
      w_frame_err_nxt  = 1'b0;
      w_overrun_nxt    = 1'b0;
      w_corr_cnt_nxt   = r_corr_cnt;

      if (!bus.ena) begin
         w_state_nxt   = IDLE;
         w_bit_idx_nxt = '0;
         w_nib_sel_nxt = 1'b0;
      end else if (bus.baud_tick) begin
         unique case (r_state)
            IDLE: begin
               if (!bus.rx_in) begin
                  w_state_nxt   = DATA;
                  w_bit_idx_nxt = '0;
               end
            end
            DATA: begin
               w_cw_nxt[r_bit_idx] = bus.rx_in;
               if (r_bit_idx == BIT_IDX_W'(CW_W - 1)) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
               end
            end
            STOP: begin
               w_state_nxt   = IDLE;
               w_bit_idx_nxt = '0;
               if (bus.rx_in) begin
                  if (w_syn != '0) begin
                     w_corr_pulse_nxt = 1'b1;
                     if (r_corr_cnt != {CNT_W{1'b1}}) begin
                        w_corr_cnt_nxt = r_corr_cnt + CNT_W'(1);
                     end
                  end
                  if (!r_nib_sel) begin
                     w_nib_hold_nxt = w_nib;
                     w_nib_sel_nxt  = 1'b1;
                  end else begin
                     w_nib_sel_nxt = 1'b0;
                     // A byte leaving in this same cycle frees the slot for the new one
                     if (!r_out_valid || bus.out_ready) begin
                        w_out_data_nxt  = w_byte;
                        w_out_valid_nxt = 1'b1;
                     end else begin
                        w_overrun_nxt = 1'b1;
                     end
                  end
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_nib_sel_nxt   = 1'b0;
               end
            end
            default: begin
               w_state_nxt   = IDLE;
               w_bit_idx_nxt = '0;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt != IDLE) || w_nib_sel_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_bit_idx    <= '0;
         r_cw         <= '0;
         r_nib_sel    <= 1'b0;
         r_nib_hold   <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_corr_pulse <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_corr_cnt   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_cw         <= w_cw_nxt;
         r_nib_sel    <= w_nib_sel_nxt;
         r_nib_hold   <= w_nib_hold_nxt;
         r_out_data   <= w_out_data_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_corr_pulse <= w_corr_pulse_nxt;
         r_frame_err  <= w_frame_err_nxt;
         r_overrun    <= w_overrun_nxt;
         r_corr_cnt   <= w_corr_cnt_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign bus.out_data   = r_out_data;
   assign bus.out_valid  = r_out_valid;
   assign bus.corr_pulse = r_corr_pulse;
   assign bus.frame_err  = r_frame_err;
   assign bus.overrun    = r_overrun;
   assign bus.corr_cnt   = r_corr_cnt;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_hamming74_rx_ctrl.sv
// Directed bench for hamming74_rx_ctrl and its hamming74_correct sub-block.
module tb_hamming74_rx_ctrl;
   import hamming74_pkg::*;

   localparam int unsigned TB_CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hamming74_rx_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

   hamming74_rx_ctrl #(
      .LSB_NIBBLE_FIRST (1'b1),
      .CNT_W            (TB_CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [6:0] u_cw;
   logic [3:0] u_nib;
   logic [2:0] u_syn;

   hamming74_correct u_corr (
      .i_cw         (u_cw),
      .o_nibble_c   (u_nib),
      .o_syndrome_c (u_syn)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_corr = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   int n_vld  = 0;
   logic [7:0] acc_q[$];

   // Pulse counters and accepted-byte capture, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.corr_pulse) n_corr++;
         if (bus.frame_err)  n_ferr++;
         if (bus.overrun)    n_ovr++;
         if (bus.out_valid)  n_vld++;
         if (bus.out_valid && bus.out_ready) acc_q.push_back(bus.out_data);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_mon();
      n_corr = 0; n_ferr = 0; n_ovr = 0; n_vld = 0;
      acc_q.delete();
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.rx_in     = b;
      bus.baud_tick = 1'b1;
      @(posedge clk); #1;
      bus.baud_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [6:0] cw, input logic stop, input logic rdy_on_stop);
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(cw[i]);
      if (rdy_on_stop) bus.out_ready = 1'b1;
      bus.rx_in     = stop;
      bus.baud_tick = 1'b1;
      @(posedge clk); #1;
      bus.baud_tick = 1'b0;
      bus.rx_in     = 1'b1;
      if (rdy_on_stop) bus.out_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   typedef struct {
      logic [6:0] cw;
      logic [2:0] syn;
      logic [3:0] nib;
   } cvec_t;

   typedef struct {
      logic [6:0] cw_a;
      logic [6:0] cw_b;
      logic [7:0] exp_byte;
      int         exp_corr;
   } vec_t;

   cvec_t cvecs[8];
   vec_t  vecs[6];
   int    exp_cnt;

   initial begin
      cvecs[0] = '{7'h2D, 3'd0, 4'h5};
      cvecs[1] = '{7'h3D, 3'd5, 4'h5};
      cvecs[2] = '{7'h52, 3'd0, 4'hA};
      cvecs[3] = '{7'h53, 3'd1, 4'hA};
      cvecs[4] = '{7'h12, 3'd7, 4'hA};
      cvecs[5] = '{7'h04, 3'd3, 4'h0};
      cvecs[6] = '{7'h77, 3'd4, 4'hF};
      cvecs[7] = '{7'h7F, 3'd0, 4'hF};

      vecs[0] = '{7'h2D, 7'h52, 8'hA5, 0};
      vecs[1] = '{7'h3D, 7'h52, 8'hA5, 1};
      vecs[2] = '{7'h52, 7'h2D, 8'h5A, 0};
      vecs[3] = '{7'h2C, 7'h12, 8'hA5, 2};
      vecs[4] = '{7'h00, 7'h7F, 8'hF0, 0};
      vecs[5] = '{7'h77, 7'h04, 8'h0F, 2};

      rst           = 1'b1;
      bus.ena       = 1'b1;
      bus.baud_tick = 1'b0;
      bus.rx_in     = 1'b1;
      bus.out_ready = 1'b1;
      u_cw          = '0;
      cycles(3);

      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_corr_cnt",  32'(bus.corr_cnt),  32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_pulses",    32'({bus.corr_pulse, bus.frame_err, bus.overrun}), 32'd0);
      rst = 1'b0;
      cycles(2);

      for (int i = 0; i < 8; i++) begin
         u_cw = cvecs[i].cw;
         #1;
         check($sformatf("corr%0d_syn", i), 32'(u_syn), 32'(cvecs[i].syn));
         check($sformatf("corr%0d_nib", i), 32'(u_nib), 32'(cvecs[i].nib));
      end

      exp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         clear_mon();
         send_frame(vecs[i].cw_a, 1'b1, 1'b0);
         send_frame(vecs[i].cw_b, 1'b1, 1'b0);
         cycles(2);
         exp_cnt += vecs[i].exp_corr;
         check($sformatf("vec%0d_nbytes", i), 32'(acc_q.size()), 32'd1);
         check($sformatf("vec%0d_byte", i),
               32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'(vecs[i].exp_byte));
         check($sformatf("vec%0d_corr_pulses", i), 32'(n_corr), 32'(vecs[i].exp_corr));
         check($sformatf("vec%0d_corr_cnt", i), 32'(bus.corr_cnt), 32'(exp_cnt));
         check($sformatf("vec%0d_valid_cycles", i), 32'(n_vld), 32'd1);
      end

      // Framing error discards the held first nibble
      clear_mon();
      send_frame(7'h52, 1'b1, 1'b0);
      check("ferr_busy_held", 32'(bus.busy), 32'd1);
      send_frame(7'h2D, 1'b0, 1'b0);
      check("ferr_pulses", 32'(n_ferr), 32'd1);
      check("ferr_busy_after", 32'(bus.busy), 32'd0);
      check("ferr_corr_cnt", 32'(bus.corr_cnt), 32'(exp_cnt));
      send_frame(7'h2D, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      cycles(2);
      check("ferr_nbytes", 32'(acc_q.size()), 32'd1);
      check("ferr_byte", 32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'hA5);

      // Overrun: second byte dropped while first is unconsumed
      clear_mon();
      bus.out_ready = 1'b0;
      send_frame(7'h2D, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      check("ovr_first_valid", 32'(bus.out_valid), 32'd1);
      send_frame(7'h52, 1'b1, 1'b0);
      send_frame(7'h2D, 1'b1, 1'b0);
      check("ovr_pulses", 32'(n_ovr), 32'd1);
      check("ovr_data_kept", 32'(bus.out_data), 32'hA5);
      check("ovr_valid_kept", 32'(bus.out_valid), 32'd1);
      check("ovr_busy", 32'(bus.busy), 32'd0);
      bus.out_ready = 1'b1;
      cycles(1);
      check("ovr_drain_valid", 32'(bus.out_valid), 32'd0);
      check("ovr_drain_byte", 32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'hA5);

      // Accept and reload in the same cycle
      clear_mon();
      bus.out_ready = 1'b0;
      send_frame(7'h2D, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      send_frame(7'h2D, 1'b1, 1'b1);
      check("b2b_first_byte", 32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'hA5);
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_data", 32'(bus.out_data), 32'h5A);
      check("b2b_no_overrun", 32'(n_ovr), 32'd0);
      bus.out_ready = 1'b1;
      cycles(1);
      bus.out_ready = 1'b0;
      check("b2b_nbytes", 32'(acc_q.size()), 32'd2);
      check("b2b_second_byte", 32'((acc_q.size() > 1) ? acc_q[1] : 8'hxx), 32'h5A);
      check("b2b_valid_clear", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;

      // Async reset in the middle of a data field
      send_frame(7'h52, 1'b1, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      #3 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_corr_cnt", 32'(bus.corr_cnt), 32'd0);
      cycles(1);
      rst = 1'b0;
      cycles(1);
      clear_mon();
      send_frame(7'h2D, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      cycles(2);
      check("arst_byte", 32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'hA5);

      // Enable dropped mid-frame; ticks while disabled are ignored
      clear_mon();
      send_frame(7'h52, 1'b1, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      bus.ena = 1'b0;
      send_bit(1'b0);
      send_bit(1'b0);
      check("ena_busy", 32'(bus.busy), 32'd0);
      check("ena_data_hold", 32'(bus.out_data), 32'hA5);
      bus.ena = 1'b1;
      bus.rx_in = 1'b1;
      cycles(1);
      send_frame(7'h2D, 1'b1, 1'b0);
      send_frame(7'h52, 1'b1, 1'b0);
      cycles(2);
      check("ena_nbytes", 32'(acc_q.size()), 32'd1);
      check("ena_byte", 32'((acc_q.size() > 0) ? acc_q[0] : 8'hxx), 32'hA5);

      // Counter saturation
      pulse_reset();
      clear_mon();
      repeat (255) send_frame(7'h3D, 1'b1, 1'b0);
      check("sat_cnt_255", 32'(bus.corr_cnt), 32'd255);
      send_frame(7'h3D, 1'b1, 1'b0);
      cycles(2);
      check("sat_cnt_hold", 32'(bus.corr_cnt), 32'd255);
      check("sat_pulses", 32'(n_corr), 32'd256);
      check("sat_nbytes", 32'(acc_q.size()), 32'd128);
      check("sat_last_byte", 32'((acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 8'hxx), 32'h55);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hamming74_rx_ctrl.md
Name: hamming74_rx_ctrl

Overview:
Receive-side controller that sequences the serial Hamming(7,4) decode path on the UART RX line. It frames each codeword (start bit, 7 code bits, stop bit) on an external bit-rate tick, runs single-bit correction, and pairs two decoded nibbles into a byte. Bytes leave through a one-entry valid/ready output register, with correction, framing and overrun status. It sits between the baud generator/line synchroniser and the byte-level consumer (FIFO or host interface).

Parameters:
LSB_NIBBLE_FIRST, 1, 1: first received codeword gives byte[3:0]; 0: it gives byte[7:4]
CNT_W, 8, width of the saturating corrected-error counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  block enable; low forces the FSM to IDLE
baud_tick  in  1  one-cycle pulse per bit period; line sampled only on tick cycles
rx_in  in  1  synchronised serial line, idle high
out_data  out  8  decoded byte
out_valid  out  1  out_data holds an unconsumed byte
out_ready  in  1  consumer accepts byte when out_valid && out_ready
corr_pulse  out  1  one-cycle pulse: codeword had nonzero syndrome and was corrected
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: completed byte dropped because holding register full
corr_cnt  out  CNT_W  count of corrected codewords, saturating at all-ones
busy  out  1  FSM not in IDLE, or first nibble held

Behaviour:
- Reset (rst high, async): FSM=IDLE, bit_idx=0, nibble_sel=0, out_data=0, out_valid=0, corr_pulse=0, frame_err=0, overrun=0, corr_cnt=0, busy=0. Reset mid-frame discards all partial data.
- FSM states: IDLE, DATA, STOP. Transitions occur only on cycles with ena && baud_tick.
- IDLE: rx_in==0 on tick -> DATA, bit_idx=0. rx_in==1 -> stay.
- DATA: on tick, cw[bit_idx]<=rx_in, bit_idx++; after bit_idx==6 -> STOP. cw[i] is Hamming position i+1 (p1..p7); parity at p1,p2,p4; data nibble = {p7,p6,p5,p3}.
- STOP, rx_in==1: syndrome s={p4^p5^p6^p7, p2^p3^p6^p7, p1^p3^p5^p7}; s!=0 -> flip position s, corr_pulse=1, corr_cnt+1 unless saturated. Corrected nibble stored per nibble_sel; nibble_sel toggles; second nibble completes the byte. -> IDLE.
- STOP, rx_in==0: frame_err=1, codeword and any held first nibble discarded, nibble_sel=0, corr_cnt unchanged -> IDLE.
- Latency: out_valid rises the cycle after the stop-bit tick of the second codeword.
- Output handshake: out_data stable while out_valid=1. If out_ready while out_valid, out_valid clears next cycle unless a byte completes in the same cycle; then the new byte loads and out_valid stays 1 (no bubble).
- Byte completes while out_valid=1 && out_ready=0: new byte dropped, old byte kept, overrun=1, nibble_sel=0.
- ena low: FSM->IDLE, nibble_sel=0, no pulses. out_data/out_valid/corr_cnt hold, and the handshake keeps working.
- baud_tick while ena=0 is ignored. No ticks -> no state change.
- Pulses are registered and last exactly one clk.

Decomposition:
- Shared package hamming74_pkg: FSM state enum (IDLE, DATA, STOP), position constants (P1..P7 indices), CW_W=7, NIB_W=4.
- Sub-module hamming74_correct: combinational, 7-bit codeword in -> 4-bit corrected nibble + 3-bit syndrome out. Reused by other Hamming paths and unit-tested alone.

Test Plan:
- Clean byte: frames cw 0x2D then 0x52, stop bits high, out_ready=1 -> out_data=0xA5, out_valid one cycle, corr_cnt=0.
- Single-bit error: first cw 0x3D (p5 flipped) then 0x52 -> corr_pulse once, syndrome 5, out_data=0xA5, corr_cnt=1.
- Framing error: cw 0x2D with low stop bit, then clean 0x2D, 0x52 -> frame_err pulse, first nibble discarded, next byte 0xA5.
- Overrun: two full bytes 0xA5 then 0x5A (cws 0x52, 0x2D), out_ready=0 -> overrun pulse, out_data stays 0xA5; raise out_ready -> out_valid clears.
- Back-to-back accept: out_ready pulsed on the byte-complete cycle of the second byte -> 0xA5 consumed, 0x5A loaded, out_valid stays high.
- Async rst mid-DATA, and ena dropped mid-frame -> IDLE, nibble_sel=0, busy=0; a following clean frame pair decodes correctly. Saturation: 256 corrected codewords with CNT_W=8 -> corr_cnt=255 holds.
